modn_cascade_counter: RTL and testbench
=======================================

MODN_CASCADE_COUNTER -- requirements
Module: modn_cascade_counter

Interface
REQ-001 The block SHALL have parameter MODULUS, default 10, giving the count range 0..MODULUS-1 of each digit (legal range 2..16).
REQ-002 The block SHALL have parameter DIGITS, default 2, giving the number of cascaded digits (legal range 1..8).
REQ-003 The block SHALL have parameter DIV, default 4, giving the prescaler divide ratio (legal range 2..256; used only under REQ-021).
REQ-004 The block SHALL derive the digit width W = clog2(MODULUS).
REQ-005 CLK  in  1  single clock; all state updates on its rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 en  in  1  count enable; sampled on the CLK edge.
REQ-008 up_dn  in  1  direction: 1 = up, 0 = down.
REQ-009 load  in  1  synchronous parallel load strobe.
REQ-010 load_val  in  DIGITS*W  load value; digit i occupies bits [i*W +: W].
REQ-011 clr_wrap  in  1  synchronous clear of wrap_flag.
REQ-012 count  out  DIGITS*W  registered count; digit 0 is least significant.
REQ-013 tc  out  1  combinational terminal count: high when tick is high and the whole count is at its wrap point for the current direction.
REQ-014 wrap_flag  out  1  sticky; set on any full-count wrap.

Function
REQ-015 The block SHALL be fully synchronous, with no derived or ripple clocks; all digits share CLK.
REQ-016 The internal tick SHALL equal en, except where REQ-021 applies.
REQ-017 Priority SHALL be: load, then tick, then hold.
  - load: count <= load_val on the next edge regardless of tick.
  - Any loaded digit >= MODULUS: that digit loads as 0.
REQ-018 Up counting on tick:
  - Digit 0 increments.
  - Digit i (i > 0) increments only when all lower digits equal MODULUS-1.
  - A digit at MODULUS-1 that increments wraps to 0.
REQ-019 Down counting on tick:
  - Digit 0 decrements.
  - Digit i (i > 0) decrements only when all lower digits equal 0.
  - A digit at 0 that decrements wraps to MODULUS-1.
REQ-020 tc and wrap_flag:
  - tc is high for exactly the one cycle whose edge performs the full wrap (up: all digits MODULUS-1; down: all digits 0).
  - On that edge wrap_flag is set.
  - clr_wrap and load each clear wrap_flag.
  - A wrap in the same cycle as clr_wrap wins, and the flag stays set.
  - A load in the same cycle as a tick suppresses the wrap, so the flag clears.
  - Latency: count and wrap_flag are visible one cycle after the qualifying edge.
  - An up_dn change takes effect on the very next tick; there is no pipeline.

Configuration
REQ-021 With macro MODN_CNT_PRESCALE_EN defined, the block SHALL include the prescaler:
  - A counter 0..DIV-1 advances only while en is high.
  - tick = en and (prescaler == DIV-1); the prescaler wraps to 0 on that edge.
  - When en is low, the prescaler holds its value.
  - load clears the prescaler.
REQ-022 With MODN_CNT_PRESCALE_EN undefined, the block SHALL contain no prescaler logic, DIV SHALL be ignored, and tick = en.

Reset
REQ-023 While reset is low, asynchronously and independent of CLK:
  - count = 0
  - wrap_flag = 0
  - prescaler = 0
  - tc = 0
REQ-024 A reset asserted mid-count SHALL abort the count immediately; counting SHALL resume from 0 on the first tick after release.

Structure
REQ-025 A shared package modn_cnt_pkg SHALL hold:
  - the defaults for MODULUS, DIGITS and DIV
  - the clog2 width function
  - the direction constants CNT_UP and CNT_DN
REQ-026 The block SHALL use one sub-module, modn_digit:
  - Inputs: CLK, reset, load, ld_val, inc, dec.
  - Outputs: q, at_max, at_zero.
  - The top instantiates DIGITS copies with a generate loop and chains their carry/borrow enables combinationally.

Verification (DIGITS=2, MODULUS=10 unless stated)
REQ-027 Reset release, en=1, up_dn=1 for 100 ticks -> count sequences 00..99; tc is high only while count==99; the next count is 00 and wrap_flag=1.
REQ-028 load=1 with load_val=0x35 (digits 3,5), then down-count 36 ticks -> count 35..00, then 99 with tc high on the 00 cycle.
REQ-029 load_val digit 0 = 12 (illegal) -> digit 0 loads 0; digit 1 loads as given.
REQ-030 Count at 98 up, up_dn toggled to 0 for one tick, then back to 1 -> count 98,97,98.
REQ-031 Wrap edge coincides with clr_wrap -> wrap_flag=1; clr_wrap alone next cycle -> wrap_flag=0; reset pulsed low mid-count at 47 -> count=00 immediately.
REQ-032 With MODN_CNT_PRESCALE_EN defined and DIV=4, en=1 for 40 cycles -> count advances every 4th cycle and reaches 10; en low for 3 cycles -> prescaler and count both hold.

Source files
------------

// File: rtl/modn_cnt_pkg.sv
// rtl/modn_cnt_pkg.sv - shared defaults, width helper and direction constants for the mod-N cascade counter
package modn_cnt_pkg;

  localparam int MODULUS_DEF = 10;
  localparam int DIGITS_DEF  = 2;
  localparam int DIV_DEF     = 4;

  localparam logic CNT_UP = 1'b1;
  localparam logic CNT_DN = 1'b0;

  // Bits needed to hold 0..v-1; never less than one bit.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    if (r < 1) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/modn_digit.sv
// rtl/modn_digit.sv - one mod-N digit with load, increment and decrement
module modn_digit
  import modn_cnt_pkg::*;
#(
  parameter int MODULUS = MODULUS_DEF,
  parameter int W       = clog2(MODULUS)
) (
  input  logic         CLK,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] ld_val,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] q,
  output logic         at_max,
  output logic         at_zero
);

  localparam logic [W-1:0] MAX_VAL = W'(MODULUS - 1);
  localparam logic [W:0]   MOD_EXT = (W + 1)'(MODULUS);

  logic ld_legal;

  assign ld_legal = ({1'b0, ld_val} < MOD_EXT);
  assign at_max   = (q == MAX_VAL);
  assign at_zero  = (q == '0);

  // Digit register: load beats counting; out-of-range load values become 0.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else if (load) begin
      q <= ld_legal ? ld_val : '0;
    end else if (inc) begin
      q <= at_max ? '0 : q + 1'b1;
    end else if (dec) begin
      q <= at_zero ? MAX_VAL : q - 1'b1;
    end
  end

endmodule

// File: rtl/modn_cascade_counter.sv
// rtl/modn_cascade_counter.sv - cascaded mod-N up/down counter, optional prescaler under MODN_CNT_PRESCALE_EN
module modn_cascade_counter
  import modn_cnt_pkg::*;
#(
  parameter int MODULUS = MODULUS_DEF,
  parameter int DIGITS  = DIGITS_DEF,
  parameter int DIV     = DIV_DEF,
  localparam int W      = clog2(MODULUS)
) (
  input  logic                CLK,
  input  logic                reset,
  input  logic                en,
  input  logic                up_dn,
  input  logic                load,
  input  logic [DIGITS*W-1:0] load_val,
  input  logic                clr_wrap,
  output logic [DIGITS*W-1:0] count,
  output logic                tc,
  output logic                wrap_flag
);

  logic              tick;
  logic [DIGITS:0]   up_chain;
  logic [DIGITS:0]   dn_chain;
  logic [DIGITS-1:0] at_max;
  logic [DIGITS-1:0] at_zero;

`ifdef MODN_CNT_PRESCALE_EN
  localparam int            PW       = clog2(DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);

  logic [PW-1:0] pre_q;

  // Prescaler: advances only while enabled, restarts on load.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      pre_q <= '0;
    end else if (load) begin
      pre_q <= '0;
    end else if (en) begin
      pre_q <= (pre_q == PRE_LAST) ? '0 : pre_q + 1'b1;
    end
  end

  assign tick = en & (pre_q == PRE_LAST);
`else
  logic [8:0] div_unused;

  assign div_unused = 9'(DIV);
  assign tick       = en;
`endif

  assign up_chain[0] = tick & (up_dn == CNT_UP);
  assign dn_chain[0] = tick & (up_dn == CNT_DN);

  // Carry/borrow ripple combinationally; every digit still clocks on CLK.
  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    assign up_chain[i+1] = up_chain[i] & at_max[i];
    assign dn_chain[i+1] = dn_chain[i] & at_zero[i];

    modn_digit #(
      .MODULUS (MODULUS),
      .W       (W)
    ) u_digit (
      .CLK     (CLK),
      .reset   (reset),
      .load    (load),
      .ld_val  (load_val[i*W +: W]),
      .inc     (up_chain[i]),
      .dec     (dn_chain[i]),
      .q       (count[i*W +: W]),
      .at_max  (at_max[i]),
      .at_zero (at_zero[i])
    );
  end

  // Full wrap happens when the carry/borrow has passed through every digit.
  assign tc = reset & (up_chain[DIGITS] | dn_chain[DIGITS]);

  // Sticky wrap flag: load clears, a wrap outranks clr_wrap.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      wrap_flag <= 1'b0;
    end else if (load) begin
      wrap_flag <= 1'b0;
    end else if (tc) begin
      wrap_flag <= 1'b1;
    end else if (clr_wrap) begin
      wrap_flag <= 1'b0;
    end
  end

endmodule

// File: tb/tb_modn_cascade_counter.sv
// tb/tb_modn_cascade_counter.sv - randomized, model-checked bench for modn_cascade_counter (MODULUS=10, DIGITS=2)
module tb_modn_cascade_counter;

  localparam int MODN = 10;
  localparam int NDIG = 2;
  localparam int DIVT = 4;
  localparam int FULL = MODN * MODN;

  logic       CLK = 1'b0;
  logic       reset = 1'b0;
  logic       en = 1'b0;
  logic       up_dn = 1'b1;
  logic       load = 1'b0;
  logic [7:0] load_val = 8'h00;
  logic       clr_wrap = 1'b0;
  logic [7:0] count;
  logic       tc;
  logic       wrap_flag;

  int n_total = 0;
  int n_pass  = 0;

  // Model state: the whole count as a plain integer 0..99.
  int m_cnt   = 0;
  int m_wrap  = 0;
  int m_pre   = 0;
  int m_ticks = 0;

  modn_cascade_counter #(
    .MODULUS (MODN),
    .DIGITS  (NDIG),
    .DIV     (DIVT)
  ) dut (
    .CLK       (CLK),
    .reset     (reset),
    .en        (en),
    .up_dn     (up_dn),
    .load      (load),
    .load_val  (load_val),
    .clr_wrap  (clr_wrap),
    .count     (count),
    .tc        (tc),
    .wrap_flag (wrap_flag)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  function automatic int to_hex(input int v);
    return ((v / MODN) << 4) | (v % MODN);
  endfunction

  function automatic int model_tick();
`ifdef MODN_CNT_PRESCALE_EN
    return (en && m_pre == DIVT - 1) ? 1 : 0;
`else
    return en ? 1 : 0;
`endif
  endfunction

  function automatic int clamp_digit(input int d);
    return (d >= MODN) ? 0 : d;
  endfunction

  // Called just after a falling edge with inputs already driven: compare, advance model, move one cycle.
  task automatic step();
    int t;
    int exp_tc;
    #1;
    t = model_tick();
    exp_tc = (t != 0 && ((up_dn && m_cnt == FULL - 1) || (!up_dn && m_cnt == 0))) ? 1 : 0;
    check("count", int'(count), to_hex(m_cnt));
    check("tc", int'(tc), exp_tc);
    check("wrap_flag", int'(wrap_flag), m_wrap);
    if (load) begin
      m_cnt  = clamp_digit(int'(load_val[7:4])) * MODN + clamp_digit(int'(load_val[3:0]));
      m_wrap = 0;
      m_pre  = 0;
    end else begin
      if (t != 0) m_cnt = up_dn ? (m_cnt + 1) % FULL : (m_cnt + FULL - 1) % FULL;
      if (exp_tc != 0) m_wrap = 1;
      else if (clr_wrap) m_wrap = 0;
      if (en) m_pre = (m_pre + 1) % DIVT;
    end
    if (t != 0) m_ticks++;
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic run_ticks(input int n);
    int target;
    int budget;
    target = m_ticks + n;
    budget = n * DIVT + 8;
    en = 1'b1;
    while (m_ticks < target && budget > 0) begin
      step();
      budget--;
    end
    if (m_ticks < target) check("tick_budget", m_ticks, target);
  endtask

  task automatic do_load(input logic [7:0] v);
    load = 1'b1;
    load_val = v;
    en = 1'b0;
    step();
    load = 1'b0;
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    #1;
    check("reset_count", int'(count), 0);
    check("reset_tc", int'(tc), 0);
    check("reset_wrap", int'(wrap_flag), 0);
    m_cnt = 0;
    m_wrap = 0;
    m_pre = 0;
    @(negedge CLK);
    reset = 1'b1;
  endtask

  initial begin
    en = 1'b1;
    up_dn = 1'b0;
    repeat (2) @(negedge CLK);
    #1;
    check("por_count", int'(count), 0);
    check("por_tc", int'(tc), 0);
    check("por_wrap", int'(wrap_flag), 0);
    reset = 1'b1;
    en = 1'b0;
    up_dn = 1'b1;
    @(negedge CLK);

    up_dn = 1'b1;
    run_ticks(99);
    check("up_99", int'(count), 'h99);
    run_ticks(1);
    check("up_wrap_cnt", int'(count), 'h00);
    check("up_wrap_flag", int'(wrap_flag), 1);

    do_load(8'h35);
    check("load_35", int'(count), 'h35);
    check("load_clr_wrap", int'(wrap_flag), 0);
    up_dn = 1'b0;
    run_ticks(35);
    check("dn_00", int'(count), 'h00);
    run_ticks(1);
    check("dn_wrap_cnt", int'(count), 'h99);
    check("dn_wrap_flag", int'(wrap_flag), 1);

    do_load(8'h7C);
    check("load_illegal", int'(count), 'h70);

    do_load(8'h98);
    up_dn = 1'b0;
    run_ticks(1);
    check("toggle_97", int'(count), 'h97);
    up_dn = 1'b1;
    run_ticks(1);
    check("toggle_98", int'(count), 'h98);

    do_load(8'h99);
    clr_wrap = 1'b1;
    run_ticks(1);
    check("wrap_beats_clr", int'(wrap_flag), 1);
    en = 1'b0;
    step();
    clr_wrap = 1'b0;
    check("clr_alone", int'(wrap_flag), 0);

    do_load(8'h47);
    pulse_reset();
    run_ticks(1);
    check("resume_01", int'(count), 'h01);

`ifdef MODN_CNT_PRESCALE_EN
    pulse_reset();
    en = 1'b1;
    up_dn = 1'b1;
    repeat (40) step();
    check("pre_40", int'(count), 'h10);
    en = 1'b0;
    repeat (3) step();
    check("pre_hold", int'(count), 'h10);
    en = 1'b1;
    repeat (3) step();
    check("pre_no_tick", int'(count), 'h10);
    step();
    check("pre_tick", int'(count), 'h11);
`endif

    for (int i = 0; i < 400; i++) begin
      en       = ($urandom_range(0, 3) != 0);
      up_dn    = $urandom_range(0, 1) != 0;
      load     = ($urandom_range(0, 15) == 0);
      load_val = 8'($urandom_range(0, 255));
      clr_wrap = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 99) == 0) pulse_reset();
      else step();
    end
    load = 1'b0;
    clr_wrap = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
